// File: rtl/iob_eth_rx_frame.sv
// Ethernet MII/GMII receive framer: finds the SFD, filters on destination MAC,
// streams dest..FCS into a byte-wide RX buffer and qualifies the frame by CRC-32 and length.
module iob_eth_rx_frame #(
    parameter int PHY_DATA_W = 4,
    parameter int BUF_ADDR_W = 11,
    parameter int MAX_FRAME  = 1518,
    parameter int MIN_FRAME  = 64,
    parameter int BCAST_EN   = 1
) (
    input  logic                  rx_clk,
    input  logic                  rx_rstn,
    input  logic                  rx_dv,
    input  logic                  rx_er,
    input  logic [PHY_DATA_W-1:0] rx_data,
    input  logic [47:0]           mac_addr,
    input  logic                  promisc,
    output logic [BUF_ADDR_W-1:0] buf_addr,
    output logic [7:0]            buf_data,
    output logic                  buf_wr,
    output logic [BUF_ADDR_W-1:0] frame_len,
    output logic                  ready,
    input  logic                  ack,
    output logic [15:0]           err_cnt
);

    localparam int CNT_W = BUF_ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, DEST, PAYLOAD, DROP, CHECK, DONE} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [47:0]       dest, dest_next;
    logic [31:0]       crc;
    logic [7:0]        rx_byte;
    logic              byte_vld;
    logic              phase;
    logic              wr_en, err_inc, crc_init, done_set, ack_clr;
    logic              addr_match, frame_good;

    // MSB-first register fed LSB-first bits; this is the bit-reverse of the
    // usual reflected form, so a clean frame leaves the residue 32'hC704DD7B.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i])
                r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
            else
                r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    generate
        if (PHY_DATA_W == 8) begin : g_gmii
            assign rx_byte  = rx_data;
            assign byte_vld = rx_dv;
            assign phase    = 1'b0;
        end else begin : g_mii
            logic [3:0] nib_lo;
            // Low nibble arrives first; phase=1 means a low nibble is held.
            always_ff @(posedge rx_clk or negedge rx_rstn) begin
                if (!rx_rstn) begin
                    nib_lo <= 4'h0;
                    phase  <= 1'b0;
                end else if (!rx_dv && state == IDLE) begin
                    phase <= 1'b0;
                end else if (rx_dv) begin
                    phase <= ~phase;
                    if (!phase)
                        nib_lo <= rx_data;
                end
            end
            assign rx_byte  = {rx_data, nib_lo};
            assign byte_vld = rx_dv & phase;
        end
    endgenerate

    assign dest_next  = {rx_byte, dest[47:8]};
    assign addr_match = promisc || (dest_next == mac_addr) || ((BCAST_EN != 0) && (&dest_next));
    assign frame_good = (crc == 32'hC704DD7B) && (cnt >= CNT_W'(MIN_FRAME)) && !phase;

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        err_inc    = 1'b0;
        crc_init   = 1'b0;
        done_set   = 1'b0;
        ack_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (byte_vld && rx_byte == 8'hD5) begin
                    state_next = DEST;
                    crc_init   = 1'b1;
                end
            end
            DEST: begin
                if (!rx_dv) begin
                    state_next = IDLE;
                    err_inc    = 1'b1;
                end else if (rx_er) begin
                    state_next = DROP;
                    err_inc    = 1'b1;
                end else if (byte_vld) begin
                    wr_en = 1'b1;
                    if (cnt == CNT_W'(5))
                        state_next = addr_match ? PAYLOAD : DROP;
                end
            end
            PAYLOAD: begin
                if (!rx_dv) begin
                    state_next = CHECK;
                end else if (rx_er) begin
                    state_next = DROP;
                    err_inc    = 1'b1;
                end else if (byte_vld) begin
                    if (cnt == CNT_W'(MAX_FRAME)) begin
                        state_next = DROP;
                        err_inc    = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!rx_dv)
                    state_next = IDLE;
            end
            CHECK: begin
                if (frame_good) begin
                    state_next = DONE;
                    done_set   = 1'b1;
                end else begin
                    state_next = IDLE;
                    err_inc    = 1'b1;
                end
            end
            DONE: begin
                if (ack) begin
                    state_next = IDLE;
                    ack_clr    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Buffer strobe is registered, so buf_addr carries the address of the byte being written.
    always_ff @(posedge rx_clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            dest      <= '0;
            crc       <= 32'hFFFFFFFF;
            buf_addr  <= '0;
            buf_data  <= 8'h00;
            buf_wr    <= 1'b0;
            frame_len <= '0;
            ready     <= 1'b0;
            err_cnt   <= 16'h0000;
        end else begin
            state  <= state_next;
            buf_wr <= wr_en;
            if (crc_init) begin
                cnt      <= '0;
                crc      <= 32'hFFFFFFFF;
                buf_addr <= '0;
            end else if (wr_en) begin
                cnt      <= cnt + CNT_W'(1);
                crc      <= crc_next(crc, rx_byte);
                buf_addr <= cnt[BUF_ADDR_W-1:0];
                buf_data <= rx_byte;
                if (state == DEST)
                    dest <= dest_next;
            end else if (ack_clr) begin
                buf_addr <= '0;
            end
            if (done_set) begin
                ready     <= 1'b1;
                frame_len <= BUF_ADDR_W'(cnt - CNT_W'(4));
            end else if (ack_clr) begin
                ready <= 1'b0;
            end
            if (err_inc && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'h0001;
        end
    end

endmodule

// File: tb/tb_iob_eth_rx_frame.sv
// Scoreboard bench for iob_eth_rx_frame: one MII and one GMII instance share a clock;
// expected buffer writes and frame lengths are queued by the stimulus and popped by monitors.
module tb_iob_eth_rx_frame;

    logic        rx_clk = 1'b0;
    logic        rstn_m = 1'b0, rstn_g = 1'b0;
    logic        dv_m = 1'b0, er_m = 1'b0, dv_g = 1'b0, er_g = 1'b0;
    logic [3:0]  data_m = 4'h0;
    logic [7:0]  data_g = 8'h00;
    logic        promisc_m = 1'b0, ack_m = 1'b0, ack_g = 1'b0;
    logic [47:0] mac_m = 48'h01_00_00_00_00_02;
    logic [47:0] mac_g = 48'h66_55_44_33_22_11;

    logic [10:0] buf_addr_m, buf_addr_g, frame_len_m, frame_len_g;
    logic [7:0]  buf_data_m, buf_data_g;
    logic        buf_wr_m, buf_wr_g, ready_m, ready_g;
    logic [15:0] err_cnt_m, err_cnt_g;

    int checks = 0;
    int passes = 0;

    logic [7:0]  frm[$];
    logic [18:0] exp_wr_m[$], exp_wr_g[$];
    logic [10:0] exp_len_m[$], exp_len_g[$];
    logic        ready_prev_m = 1'b0, ready_prev_g = 1'b0;

    iob_eth_rx_frame #(.PHY_DATA_W(4)) dut_mii (
        .rx_clk(rx_clk), .rx_rstn(rstn_m), .rx_dv(dv_m), .rx_er(er_m), .rx_data(data_m),
        .mac_addr(mac_m), .promisc(promisc_m), .buf_addr(buf_addr_m), .buf_data(buf_data_m),
        .buf_wr(buf_wr_m), .frame_len(frame_len_m), .ready(ready_m), .ack(ack_m),
        .err_cnt(err_cnt_m)
    );

    iob_eth_rx_frame #(.PHY_DATA_W(8)) dut_gmii (
        .rx_clk(rx_clk), .rx_rstn(rstn_g), .rx_dv(dv_g), .rx_er(er_g), .rx_data(data_g),
        .mac_addr(mac_g), .promisc(1'b0), .buf_addr(buf_addr_g), .buf_data(buf_data_g),
        .buf_wr(buf_wr_g), .frame_len(frame_len_g), .ready(ready_g), .ack(ack_g),
        .err_cnt(err_cnt_g)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference CRC in the standard reflected form, independent of the DUT's bit ordering.
    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic buildFrame(input logic [47:0] dest, input int plen, input int flip_at);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dest[8*i +: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'(8'h10 + i));
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        for (int i = 0; i < plen; i++) frm.push_back(8'((i * 7 + 3) & 8'hFF));
        c = 32'hFFFFFFFF;
        foreach (frm[i]) c = crcByte(c, frm[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
        if (flip_at >= 0) frm[flip_at] = frm[flip_at] ^ 8'h01;
    endtask

    task automatic sendByte(input bit gmii, input logic [7:0] b, input bit er);
        if (gmii) begin
            @(posedge rx_clk); #1;
            dv_g = 1'b1; data_g = b; er_g = er;
        end else begin
            @(posedge rx_clk); #1;
            dv_m = 1'b1; data_m = b[3:0]; er_m = er;
            @(posedge rx_clk); #1;
            data_m = b[7:4]; er_m = 1'b0;
        end
    endtask

    task automatic applyStimulus(input bit gmii, input int nwr, input bit good,
                                 input int er_at, input int rst_at);
        for (int i = 0; i < nwr; i++) begin
            if (gmii) exp_wr_g.push_back({11'(i), frm[i]});
            else      exp_wr_m.push_back({11'(i), frm[i]});
        end
        if (good) begin
            if (gmii) exp_len_g.push_back(11'(frm.size() - 4));
            else      exp_len_m.push_back(11'(frm.size() - 4));
        end
        for (int i = 0; i < 8; i++) sendByte(gmii, (i == 7) ? 8'hD5 : 8'h55, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            if (i == rst_at) begin
                @(posedge rx_clk);
                @(negedge rx_clk); #1;
                rstn_m = 1'b0;
                #1;
                checkOutput("mii async reset buf_wr", 32'(buf_wr_m), 0);
                checkOutput("mii async reset buf_addr", 32'(buf_addr_m), 0);
                checkOutput("mii async reset buf_data", 32'(buf_data_m), 0);
                checkOutput("mii async reset ready", 32'(ready_m), 0);
                checkOutput("mii async reset frame_len", 32'(frame_len_m), 0);
                checkOutput("mii async reset err_cnt", 32'(err_cnt_m), 0);
                dv_m = 1'b0; data_m = 4'h0;
                @(negedge rx_clk);
                rstn_m = 1'b1;
                repeat (4) @(posedge rx_clk);
                return;
            end
            sendByte(gmii, frm[i], i == er_at);
        end
        @(posedge rx_clk); #1;
        dv_m = 1'b0; dv_g = 1'b0; er_m = 1'b0; er_g = 1'b0; data_m = 4'h0; data_g = 8'h00;
        repeat (12) @(posedge rx_clk);
    endtask

    task automatic doAck(input bit gmii);
        @(posedge rx_clk); #1;
        if (gmii) ack_g = 1'b1; else ack_m = 1'b1;
        @(posedge rx_clk); #1;
        ack_g = 1'b0; ack_m = 1'b0;
        if (gmii) begin
            checkOutput("gmii ready after ack", 32'(ready_g), 0);
            checkOutput("gmii buf_addr after ack", 32'(buf_addr_g), 0);
        end else begin
            checkOutput("mii ready after ack", 32'(ready_m), 0);
            checkOutput("mii buf_addr after ack", 32'(buf_addr_m), 0);
        end
    endtask

    // Monitors pop the scoreboard on every buffer write and on every rising ready.
    always @(negedge rx_clk) begin
        logic [18:0] e;
        if (buf_wr_m) begin
            if (exp_wr_m.size() == 0) begin
                checkOutput("mii unexpected buf_wr addr", 32'(buf_addr_m), 32'h7FF);
            end else begin
                e = exp_wr_m.pop_front();
                checkOutput("mii buf_wr addr/data", {13'h0, buf_addr_m, buf_data_m}, {13'h0, e});
            end
        end
        if (buf_wr_g) begin
            if (exp_wr_g.size() == 0) begin
                checkOutput("gmii unexpected buf_wr addr", 32'(buf_addr_g), 32'h7FF);
            end else begin
                e = exp_wr_g.pop_front();
                checkOutput("gmii buf_wr addr/data", {13'h0, buf_addr_g, buf_data_g}, {13'h0, e});
            end
        end
        if (ready_m && !ready_prev_m)
            checkOutput("mii frame_len on ready", 32'(frame_len_m),
                        (exp_len_m.size() != 0) ? 32'(exp_len_m.pop_front()) : 32'hDEAD);
        if (ready_g && !ready_prev_g)
            checkOutput("gmii frame_len on ready", 32'(frame_len_g),
                        (exp_len_g.size() != 0) ? 32'(exp_len_g.pop_front()) : 32'hDEAD);
        ready_prev_m = ready_m;
        ready_prev_g = ready_g;
    end

    initial begin
        #1;
        checkOutput("mii reset buf_addr", 32'(buf_addr_m), 0);
        checkOutput("mii reset buf_wr", 32'(buf_wr_m), 0);
        checkOutput("mii reset ready", 32'(ready_m), 0);
        checkOutput("mii reset err_cnt", 32'(err_cnt_m), 0);
        checkOutput("gmii reset ready", 32'(ready_g), 0);
        checkOutput("gmii reset frame_len", 32'(frame_len_g), 0);
        #21;
        rstn_m = 1'b1;
        rstn_g = 1'b1;
        repeat (3) @(posedge rx_clk);

        $display("[TB] MII unicast good frame");
        buildFrame(48'h01_00_00_00_00_02, 46, -1);
        applyStimulus(0, 64, 1, -1, -1);
        checkOutput("mii good ready", 32'(ready_m), 1);
        checkOutput("mii good err_cnt", 32'(err_cnt_m), 0);
        doAck(0);

        $display("[TB] MII payload bit flipped");
        buildFrame(48'h01_00_00_00_00_02, 46, 20);
        applyStimulus(0, 64, 0, -1, -1);
        checkOutput("mii crc-bad ready", 32'(ready_m), 0);
        checkOutput("mii crc-bad err_cnt", 32'(err_cnt_m), 1);

        $display("[TB] MII foreign dest, promisc off then on");
        buildFrame(48'h02_00_00_00_00_02, 46, -1);
        applyStimulus(0, 6, 0, -1, -1);
        checkOutput("mii filtered ready", 32'(ready_m), 0);
        checkOutput("mii filtered err_cnt", 32'(err_cnt_m), 1);
        promisc_m = 1'b1;
        applyStimulus(0, 64, 1, -1, -1);
        checkOutput("mii promisc ready", 32'(ready_m), 1);
        doAck(0);
        promisc_m = 1'b0;

        $display("[TB] MII frame while ready held");
        buildFrame(48'h01_00_00_00_00_02, 50, -1);
        applyStimulus(0, 68, 1, -1, -1);
        buildFrame(48'h01_00_00_00_00_02, 46, -1);
        applyStimulus(0, 0, 0, -1, -1);
        checkOutput("mii held ready", 32'(ready_m), 1);
        checkOutput("mii held frame_len", 32'(frame_len_m), 64);
        checkOutput("mii held err_cnt", 32'(err_cnt_m), 1);
        doAck(0);
        applyStimulus(0, 64, 1, -1, -1);
        checkOutput("mii third frame ready", 32'(ready_m), 1);
        doAck(0);

        $display("[TB] MII rx_er mid-payload");
        applyStimulus(0, 30, 0, 30, -1);
        checkOutput("mii rx_er ready", 32'(ready_m), 0);
        checkOutput("mii rx_er err_cnt", 32'(err_cnt_m), 2);

        $display("[TB] MII reset mid-frame, then good frame");
        applyStimulus(0, 20, 0, -1, 20);
        applyStimulus(0, 64, 1, -1, -1);
        checkOutput("mii post-reset ready", 32'(ready_m), 1);
        checkOutput("mii post-reset err_cnt", 32'(err_cnt_m), 0);
        doAck(0);

        $display("[TB] GMII broadcast 1519 then 1518 bytes");
        buildFrame(48'hFFFF_FFFF_FFFF, 1501, -1);
        applyStimulus(1, 1518, 0, -1, -1);
        checkOutput("gmii oversize ready", 32'(ready_g), 0);
        checkOutput("gmii oversize err_cnt", 32'(err_cnt_g), 1);
        buildFrame(48'hFFFF_FFFF_FFFF, 1500, -1);
        applyStimulus(1, 1518, 1, -1, -1);
        checkOutput("gmii max ready", 32'(ready_g), 1);
        checkOutput("gmii max frame_len", 32'(frame_len_g), 1514);
        checkOutput("gmii max err_cnt", 32'(err_cnt_g), 1);
        doAck(1);

        repeat (4) @(posedge rx_clk);
        checkOutput("mii write queue drained", 32'(exp_wr_m.size()), 0);
        checkOutput("gmii write queue drained", 32'(exp_wr_g.size()), 0);
        checkOutput("mii length queue drained", 32'(exp_len_m.size()), 0);
        checkOutput("gmii length queue drained", 32'(exp_len_g.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
